// File: rtl/uart_rx_frame.sv
// Serial byte receiver: synchronizes rx, samples each bit at mid-period and
// validates the stop bit before presenting the byte with a one-cycle strobe.
module uart_rx_frame #(
    parameter int BAUDRATE = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr,
    output logic       busy
);

    localparam int DIV_W = (BAUDRATE > 2) ? $clog2(BAUDRATE) : 1;
    // The divider counts down to zero, so loads are one less than the period.
    localparam logic [DIV_W-1:0] HALF_LOAD = DIV_W'(BAUDRATE / 2 - 1);
    localparam logic [DIV_W-1:0] FULL_LOAD = DIV_W'(BAUDRATE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rx_p0;
    logic             rx_s;
    logic [DIV_W-1:0] div;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             expired;
    logic             load_half;
    logic             load_full;
    logic             clr_cnt;
    logic             shift;
    logic             take;
    logic             frame_err;

    assign expired = (div == '0);
    assign busy    = (state != IDLE);

    // Synchronizer stage: preset high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_s  <= rx_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_half  = 1'b0;
        load_full  = 1'b0;
        clr_cnt    = 1'b0;
        shift      = 1'b0;
        take       = 1'b0;
        frame_err  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    load_half  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (expired) begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        load_full  = 1'b1;
                        clr_cnt    = 1'b1;
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (expired) begin
                    shift     = 1'b1;
                    load_full = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (expired) begin
                    if (rx_s) begin
                        take       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err  = 1'b1;
                        state_next = BRK;
                    end
                end
            end
            BRK: begin
                // A line held low must go high before a new start is accepted.
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= '0;
            bit_cnt <= 3'd0;
        end else begin
            if (load_half) begin
                div <= HALF_LOAD;
            end else if (load_full) begin
                div <= FULL_LOAD;
            end else if (!expired) begin
                div <= div - DIV_W'(1);
            end
            if (clr_cnt) begin
                bit_cnt <= 3'd0;
            end else if (shift) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // LSB arrives first, so shifting right leaves bit 0 at shreg[0].
    always_ff @(posedge clk) begin
        if (shift) begin
            shreg <= {rx_s, shreg[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= 8'h00;
            rcv  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            rcv  <= take;
            ferr <= frame_err;
            if (take) begin
                data <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with two instances (BAUDRATE 16 and 104)
// sharing clock and reset.
module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx16 = 1'b1;
    logic       rx104 = 1'b1;
    logic [7:0] data16;
    logic [7:0] data104;
    logic       rcv16;
    logic       rcv104;
    logic       ferr16;
    logic       ferr104;
    logic       busy16;
    logic       busy104;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int both_cnt = 0;

    logic [7:0] rcv_q16[$];
    int         rcv_cyc16[$];
    int         ferr_cyc16[$];
    logic [7:0] rcv_q104[$];
    int         rcv_cyc104[$];
    int         ferr_cyc104[$];

    uart_rx_frame #(.BAUDRATE(16)) dut16 (
        .clk(clk), .rst(rst), .rx(rx16),
        .data(data16), .rcv(rcv16), .ferr(ferr16), .busy(busy16)
    );

    uart_rx_frame #(.BAUDRATE(104)) dut104 (
        .clk(clk), .rst(rst), .rx(rx104),
        .data(data104), .rcv(rcv104), .ferr(ferr104), .busy(busy104)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rcv16) begin
            rcv_q16.push_back(data16);
            rcv_cyc16.push_back(cyc);
        end
        if (ferr16) ferr_cyc16.push_back(cyc);
        if (rcv104) begin
            rcv_q104.push_back(data104);
            rcv_cyc104.push_back(cyc);
        end
        if (ferr104) ferr_cyc104.push_back(cyc);
        if ((rcv16 && ferr16) || (rcv104 && ferr104)) both_cnt++;
    end

    // Called just after a negedge; drives start, 8 data bits LSB first, stop.
    task automatic send(input bit big, input logic [7:0] b, input logic stop_bit);
        int bw;
        bw = big ? 104 : 16;
        if (big) rx104 = 1'b0; else rx16 = 1'b0;
        repeat (bw) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (big) rx104 = b[i]; else rx16 = b[i];
            repeat (bw) @(negedge clk);
        end
        if (big) rx104 = stop_bit; else rx16 = stop_bit;
        repeat (bw) @(negedge clk);
    endtask

    task automatic clear_logs();
        rcv_q16.delete();
        rcv_cyc16.delete();
        ferr_cyc16.delete();
        rcv_q104.delete();
        rcv_cyc104.delete();
        ferr_cyc104.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({data16, rcv16, ferr16, busy16} !== 11'h000) begin
            errors++;
            $display("FAIL reset16: got data=%h rcv=%b ferr=%b busy=%b expected 00 0 0 0",
                     data16, rcv16, ferr16, busy16);
        end
        checks++;
        if ({data104, rcv104, ferr104, busy104} !== 11'h000) begin
            errors++;
            $display("FAIL reset104: got data=%h rcv=%b ferr=%b busy=%b expected 00 0 0 0",
                     data104, rcv104, ferr104, busy104);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (busy16 !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset: cycle %0d busy=%b expected 0", i, busy16);
            end
        end
        clear_logs();
    endtask

    task automatic test_single();
        int t0;
        repeat (20) @(negedge clk);
        t0 = cyc;
        send(1'b0, 8'h55, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (rcv_q16.size() !== 1) begin
            errors++;
            $display("FAIL single_rcv_count: got %0d expected 1", rcv_q16.size());
        end
        checks++;
        if (data16 !== 8'h55) begin
            errors++;
            $display("FAIL single_data: got %h expected 55", data16);
        end
        checks++;
        if (rcv_cyc16.size() < 1 || rcv_cyc16[0] !== t0 + 155) begin
            errors++;
            $display("FAIL single_timing: got cycle %0d expected %0d",
                     (rcv_cyc16.size() > 0) ? rcv_cyc16[0] : -1, t0 + 155);
        end
        checks++;
        if (ferr_cyc16.size() !== 0) begin
            errors++;
            $display("FAIL single_ferr: got %0d pulses expected 0", ferr_cyc16.size());
        end
        checks++;
        if (busy16 !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: got %b expected 0", busy16);
        end
    endtask

    task automatic test_two_frames_104();
        int t0;
        int t1;
        clear_logs();
        repeat (20) @(negedge clk);
        t0 = cyc;
        send(1'b1, 8'h55, 1'b1);
        repeat (416) @(negedge clk);
        t1 = cyc;
        send(1'b1, 8'h4B, 1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if (rcv_q104.size() !== 2) begin
            errors++;
            $display("FAIL b104_count: got %0d expected 2", rcv_q104.size());
        end
        checks++;
        if (rcv_q104.size() < 1 || rcv_q104[0] !== 8'h55) begin
            errors++;
            $display("FAIL b104_first_data: got %h expected 55",
                     (rcv_q104.size() > 0) ? rcv_q104[0] : 8'hxx);
        end
        checks++;
        if (rcv_q104.size() < 2 || rcv_q104[1] !== 8'h4B) begin
            errors++;
            $display("FAIL b104_second_data: got %h expected 4b",
                     (rcv_q104.size() > 1) ? rcv_q104[1] : 8'hxx);
        end
        checks++;
        if (rcv_cyc104.size() < 1 || rcv_cyc104[0] !== t0 + 991) begin
            errors++;
            $display("FAIL b104_first_timing: got %0d expected %0d",
                     (rcv_cyc104.size() > 0) ? rcv_cyc104[0] : -1, t0 + 991);
        end
        checks++;
        if (rcv_cyc104.size() < 2 || rcv_cyc104[1] !== t1 + 991) begin
            errors++;
            $display("FAIL b104_second_timing: got %0d expected %0d",
                     (rcv_cyc104.size() > 1) ? rcv_cyc104[1] : -1, t1 + 991);
        end
        checks++;
        if (ferr_cyc104.size() !== 0 || data104 !== 8'h4B) begin
            errors++;
            $display("FAIL b104_final: got ferr=%0d data=%h expected 0 4b",
                     ferr_cyc104.size(), data104);
        end
    endtask

    task automatic test_glitch();
        clear_logs();
        repeat (10) @(negedge clk);
        rx16 = 1'b0;
        repeat (5) @(negedge clk);
        rx16 = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy16 !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_at_sample: got %b expected 1", busy16);
        end
        @(negedge clk);
        checks++;
        if (busy16 !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle_after_sample: got %b expected 0", busy16);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (rcv_q16.size() !== 0 || ferr_cyc16.size() !== 0) begin
            errors++;
            $display("FAIL glitch_strobes: got rcv=%0d ferr=%0d expected 0 0",
                     rcv_q16.size(), ferr_cyc16.size());
        end
        checks++;
        if (data16 !== 8'h55) begin
            errors++;
            $display("FAIL glitch_data: got %h expected 55", data16);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        clear_logs();
        repeat (10) @(negedge clk);
        t0 = cyc;
        send(1'b0, 8'hFF, 1'b1);
        t1 = cyc;
        send(1'b0, 8'h00, 1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if (rcv_q16.size() !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 2", rcv_q16.size());
        end
        checks++;
        if (rcv_q16.size() < 1 || rcv_q16[0] !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_first_data: got %h expected ff",
                     (rcv_q16.size() > 0) ? rcv_q16[0] : 8'hxx);
        end
        checks++;
        if (rcv_q16.size() < 2 || rcv_q16[1] !== 8'h00) begin
            errors++;
            $display("FAIL b2b_second_data: got %h expected 00",
                     (rcv_q16.size() > 1) ? rcv_q16[1] : 8'hxx);
        end
        checks++;
        if (rcv_cyc16.size() < 2 || rcv_cyc16[0] !== t0 + 155 || rcv_cyc16[1] !== t1 + 155) begin
            errors++;
            $display("FAIL b2b_timing: got %0d,%0d expected %0d,%0d",
                     (rcv_cyc16.size() > 0) ? rcv_cyc16[0] : -1,
                     (rcv_cyc16.size() > 1) ? rcv_cyc16[1] : -1, t0 + 155, t1 + 155);
        end
        checks++;
        if (ferr_cyc16.size() !== 0) begin
            errors++;
            $display("FAIL b2b_ferr: got %0d expected 0", ferr_cyc16.size());
        end
    endtask

    task automatic test_frame_error();
        int t0;
        clear_logs();
        repeat (10) @(negedge clk);
        t0 = cyc;
        send(1'b0, 8'hA3, 1'b0);
        repeat (20) @(negedge clk);
        checks++;
        if (ferr_cyc16.size() !== 1) begin
            errors++;
            $display("FAIL ferr_count: got %0d expected 1", ferr_cyc16.size());
        end
        checks++;
        if (ferr_cyc16.size() < 1 || ferr_cyc16[0] !== t0 + 155) begin
            errors++;
            $display("FAIL ferr_timing: got %0d expected %0d",
                     (ferr_cyc16.size() > 0) ? ferr_cyc16[0] : -1, t0 + 155);
        end
        checks++;
        if (busy16 !== 1'b1) begin
            errors++;
            $display("FAIL ferr_break_busy: got %b expected 1", busy16);
        end
        checks++;
        if (data16 !== 8'h00 || rcv_q16.size() !== 0) begin
            errors++;
            $display("FAIL ferr_data_kept: got data=%h rcv=%0d expected 00 0",
                     data16, rcv_q16.size());
        end
        repeat (20) @(negedge clk);
        rx16 = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy16 !== 1'b0) begin
            errors++;
            $display("FAIL ferr_break_exit: got busy=%b expected 0", busy16);
        end
        checks++;
        if (rcv_q16.size() !== 0 || ferr_cyc16.size() !== 1) begin
            errors++;
            $display("FAIL ferr_no_new_frame: got rcv=%0d ferr=%0d expected 0 1",
                     rcv_q16.size(), ferr_cyc16.size());
        end
        send(1'b0, 8'h3C, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (rcv_q16.size() !== 1 || data16 !== 8'h3C) begin
            errors++;
            $display("FAIL ferr_recover: got rcv=%0d data=%h expected 1 3c",
                     rcv_q16.size(), data16);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        repeat (10) @(negedge clk);
        fork
            send(1'b0, 8'h81, 1'b1);
            begin
                repeat (85) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checks++;
                if ({data16, rcv16, ferr16, busy16} !== 11'h000) begin
                    errors++;
                    $display("FAIL rst_mid_outputs: got data=%h rcv=%b ferr=%b busy=%b expected 00 0 0 0",
                             data16, rcv16, ferr16, busy16);
                end
            end
        join
        checks++;
        if (rcv_q16.size() !== 0 || ferr_cyc16.size() !== 0) begin
            errors++;
            $display("FAIL rst_mid_no_strobe: got rcv=%0d ferr=%0d expected 0 0",
                     rcv_q16.size(), ferr_cyc16.size());
        end
        repeat (150) @(negedge clk);
        clear_logs();
        send(1'b0, 8'h81, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (rcv_q16.size() !== 1 || data16 !== 8'h81) begin
            errors++;
            $display("FAIL rst_mid_recover: got rcv=%0d data=%h expected 1 81",
                     rcv_q16.size(), data16);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_frames_104();
        test_glitch();
        test_back_to_back();
        test_frame_error();
        test_reset_mid_frame();
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL rcv_ferr_overlap: got %0d cycles expected 0", both_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
